// File: rtl/branch_cmp_predict.sv
// Branch resolution unit: RV32I compare, registered outcome/mispredict flags,
// PC-indexed 2-bit saturating predictor table and saturating perf counters.
module branch_cmp_predict #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic [6:0]       res_opcode,
  input  logic [2:0]       res_funct3,
  input  logic [WIDTH-1:0] res_a,
  input  logic [WIDTH-1:0] res_b,
  input  logic             res_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  output logic             br_en,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cmp_taken;
  logic             is_branch;
  logic             f3_legal;
  logic             accept;
  logic             br_upd;
  logic             br_mp;
  logic             unused_pc_bits;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign res_idx  = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            res_pc[31:IDX_W+2], res_pc[1:0]};

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cmp_taken = 1'b0;
    f3_legal  = 1'b1;
    case (funct3_e'(res_funct3))
      F3_BEQ:  cmp_taken = (res_a == res_b);
      F3_BNE:  cmp_taken = (res_a != res_b);
      F3_BLT:  cmp_taken = ($signed(res_a) <  $signed(res_b));
      F3_BGE:  cmp_taken = ($signed(res_a) >= $signed(res_b));
      F3_BLTU: cmp_taken = (res_a <  res_b);
      F3_BGEU: cmp_taken = (res_a >= res_b);
      default: f3_legal  = 1'b0;
    endcase
  end

  assign is_branch = (res_opcode == OP_BRANCH);
  assign accept    = res_valid & ~flush;
  assign br_upd    = accept & is_branch & f3_legal;
  assign br_mp     = cmp_taken ^ res_pred_taken;

  // Asynchronous read gives the pre-update value on a same-index collision.
  assign pred_taken = bht[pred_idx][1];

  // NOTE: the predictor table is reset entry-by-entry because power-up prediction must be
  // weakly not-taken; this forces flops rather than a RAM macro, acceptable at this depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (br_upd) begin
      if (cmp_taken) begin
        if (bht[res_idx] != 2'b11) bht[res_idx] <= bht[res_idx] + 2'b01;
      end else begin
        if (bht[res_idx] != 2'b00) bht[res_idx] <= bht[res_idx] - 2'b01;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      br_en      <= 1'b0;
      mispredict <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      out_valid  <= accept;
      br_en      <= br_upd & cmp_taken;
      mispredict <= br_upd & br_mp;
      illegal    <= accept & is_branch & ~f3_legal;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (br_upd && (br_count != '1)) br_count <= br_count + 1'b1;
      if (br_upd && br_mp && (mp_count != '1)) mp_count <= mp_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_cmp_predict.sv
// Directed bench for branch_cmp_predict; a second instance with CNT_W=4
// shares the stimulus to exercise counter saturation.
module tb_branch_cmp_predict;

  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken, pred_taken4;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [6:0]  res_opcode;
  logic [2:0]  res_funct3;
  logic [31:0] res_a, res_b;
  logic        res_pred_taken;
  logic        flush;
  logic        out_valid, br_en, mispredict, illegal;
  logic        out_valid4, br_en4, mispredict4, illegal4;
  logic [31:0] br_count, mp_count;
  logic [3:0]  br_count4, mp_count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_cmp_predict u_dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_opcode(res_opcode),
    .res_funct3(res_funct3), .res_a(res_a), .res_b(res_b),
    .res_pred_taken(res_pred_taken), .flush(flush), .out_valid(out_valid),
    .br_en(br_en), .mispredict(mispredict), .illegal(illegal),
    .br_count(br_count), .mp_count(mp_count)
  );

  branch_cmp_predict #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken4),
    .res_valid(res_valid), .res_pc(res_pc), .res_opcode(res_opcode),
    .res_funct3(res_funct3), .res_a(res_a), .res_b(res_b),
    .res_pred_taken(res_pred_taken), .flush(flush), .out_valid(out_valid4),
    .br_en(br_en4), .mispredict(mispredict4), .illegal(illegal4),
    .br_count(br_count4), .mp_count(mp_count4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one request for a single edge; outputs are then valid until the next edge.
  task automatic resolve(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic pt,
                         input logic fl);
    res_valid = 1'b1; res_pc = pc; res_opcode = op; res_funct3 = f3;
    res_a = a; res_b = b; res_pred_taken = pt; flush = fl;
    @(posedge clk); #1;
    res_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic v, input logic be,
                             input logic mp, input logic il);
    check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
    check({tag, ".br_en"}, {31'b0, br_en}, {31'b0, be});
    check({tag, ".mispredict"}, {31'b0, mispredict}, {31'b0, mp});
    check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, il});
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    pred_pc = pc; #1;
    check(tag, {31'b0, pred_taken}, {31'b0, exp});
  endtask

  initial begin
    rst = 1'b1; pred_pc = '0; res_valid = 1'b0; res_pc = '0; res_opcode = '0;
    res_funct3 = '0; res_a = '0; res_b = '0; res_pred_taken = 1'b0; flush = 1'b0;
    #12;
    check_flags("reset", 0, 0, 0, 0);
    check("reset.br_count", br_count, 0);
    check("reset.mp_count", mp_count, 0);
    @(negedge clk); rst = 1'b0;
    check_pred("reset.pred_0x0", 32'h0, 0);
    check_pred("reset.pred_0xFC", 32'hFC, 0);

    // blt -1 < 1 taken, predicted not-taken
    resolve(32'h10, OP_BR, 3'b100, 32'hFFFF_FFFF, 32'h1, 0, 0);
    check_flags("blt_neg", 1, 1, 1, 0);
    check("blt_neg.br_count", br_count, 1);
    check("blt_neg.mp_count", mp_count, 1);
    check_pred("blt_neg.pred", 32'h10, 1);
    @(posedge clk); #1;
    check_flags("idle_after", 0, 0, 0, 0);

    resolve(32'h20, OP_BR, 3'b100, 32'h8000_0000, 32'h1, 1, 0);
    check_flags("blt_min", 1, 1, 0, 0);
    resolve(32'h20, OP_BR, 3'b110, 32'h8000_0000, 32'h1, 0, 0);
    check_flags("bltu_min", 1, 0, 0, 0);
    resolve(32'h20, OP_BR, 3'b101, 32'h8000_0000, 32'h1, 0, 0);
    check_flags("bge_min", 1, 0, 0, 0);
    resolve(32'h20, OP_BR, 3'b111, 32'h8000_0000, 32'h1, 0, 0);
    check_flags("bgeu_min", 1, 1, 1, 0);
    resolve(32'h20, OP_BR, 3'b000, 32'h1234, 32'h1234, 1, 0);
    check_flags("beq_eq", 1, 1, 0, 0);
    resolve(32'h20, OP_BR, 3'b001, 32'h1234, 32'h1234, 0, 0);
    check_flags("bne_eq", 1, 0, 0, 0);
    resolve(32'h20, OP_BR, 3'b101, 32'h5, 32'h5, 1, 0);
    check_flags("bge_eq", 1, 1, 0, 0);
    check("cmp.br_count", br_count, 8);
    check("cmp.mp_count", mp_count, 2);

    // Saturation at 0x40: 01 -> 11 after four taken, then two not-taken -> 01
    for (int i = 0; i < 4; i++) resolve(32'h40, OP_BR, 3'b000, 32'h0, 32'h0, 0, 0);
    check_pred("sat.after_taken", 32'h40, 1);
    resolve(32'h40, OP_BR, 3'b001, 32'h7, 32'h7, 1, 0);
    check_flags("sat.nt1", 1, 0, 1, 0);
    check_pred("sat.after_nt1", 32'h40, 1);
    resolve(32'h40, OP_BR, 3'b001, 32'h7, 32'h7, 1, 0);
    check_pred("sat.after_nt2", 32'h40, 0);
    check("sat.br_count", br_count, 14);
    check("sat.mp_count", mp_count, 8);

    // Same-cycle collision at 0x80: old value visible until the edge
    pred_pc = 32'h80;
    res_valid = 1'b1; res_pc = 32'h80; res_opcode = OP_BR; res_funct3 = 3'b000;
    res_a = 32'h3; res_b = 32'h3; res_pred_taken = 1'b0; flush = 1'b0;
    #1;
    check("collide.same_cycle", {31'b0, pred_taken}, 0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    check("collide.next_cycle", {31'b0, pred_taken}, 1);

    // Filtering: illegal funct3 (0x80 is at 2'b10; any update would move it)
    resolve(32'h80, OP_BR, 3'b010, 32'h3, 32'h3, 1, 0);
    check_flags("illegal_010", 1, 0, 0, 1);
    resolve(32'h80, OP_BR, 3'b011, 32'h3, 32'h4, 1, 0);
    check_flags("illegal_011", 1, 0, 0, 1);
    check_pred("illegal.pred", 32'h80, 1);
    resolve(32'h40, OP_IMM, 3'b000, 32'h3, 32'h3, 1, 0);
    check_flags("non_branch", 1, 0, 0, 0);
    check_pred("non_branch.pred", 32'h40, 0);
    resolve(32'h40, OP_BR, 3'b000, 32'h3, 32'h3, 0, 1);
    check_flags("flush", 0, 0, 0, 0);
    check_pred("flush.pred", 32'h40, 0);
    check("filter.br_count", br_count, 15);
    check("filter.mp_count", mp_count, 9);

    // Asynchronous reset mid-stream with a request pending
    resolve(32'h10, OP_BR, 3'b000, 32'h1, 32'h1, 0, 0);
    check("pre_rst.out_valid", {31'b0, out_valid}, 1);
    res_valid = 1'b1; res_pc = 32'h10; res_opcode = OP_BR; res_funct3 = 3'b000;
    res_a = 32'h1; res_b = 32'h1; res_pred_taken = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_flags("mid_rst", 0, 0, 0, 0);
    check("mid_rst.br_count", br_count, 0);
    check("mid_rst.mp_count", mp_count, 0);
    check_pred("mid_rst.pred_0x10", 32'h10, 0);
    check_pred("mid_rst.pred_0x80", 32'h80, 0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(negedge clk); rst = 1'b0;

    // 20 mispredicting branches after reset
    resolve(32'h0, OP_BR, 3'b000, 32'h9, 32'h9, 0, 0);
    check_flags("post_rst.first", 1, 1, 1, 0);
    check("post_rst.br_count", br_count, 1);
    for (int i = 1; i < 20; i++) resolve(32'h0, OP_BR, 3'b000, 32'h9, 32'h9, 0, 0);
    check("wide.br_count", br_count, 20);
    check("wide.mp_count", mp_count, 20);
    check("sat4.br_count", {28'b0, br_count4}, 15);
    check("sat4.mp_count", {28'b0, mp_count4}, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
